// File: rtl/decode_stage.sv
// Registered decode stage between fetch and rename: per-lane decode into a 2-entry skid FIFO.
// Optional `DECODE_ILLEGAL_TRAP_EN: flag illegal lanes and zero their control, ALU op and immediate.
module decode_stage #(
  parameter int unsigned LANES = 1,
  parameter int unsigned PC_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [32*LANES-1:0]   in_instr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [PC_W*LANES-1:0] out_pc,
  output logic [32*LANES-1:0]   out_instr,
  output logic [7*LANES-1:0]    out_c_sig,
  output logic [3*LANES-1:0]    out_alu_sig,
  output logic [32*LANES-1:0]   out_imm,
  output logic [5*LANES-1:0]    out_rd,
  output logic [5*LANES-1:0]    out_rs1,
  output logic [5*LANES-1:0]    out_rs2,
  output logic [LANES-1:0]      out_illegal
);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluXor = 3'b001;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluSr  = 3'b100;
  localparam logic [2:0] AluSl  = 3'b101;

  typedef struct packed {
    logic [6:0]  c;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic       legal;
    logic [2:0] f3;
    f3    = ins[14:12];
    d     = '0;
    legal = 1'b0;
    case (ins[6:0])
      OpR: begin
        d.c   = 7'h41;
        legal = (f3 == 3'b000) || (f3 == 3'b100) || (f3 == 3'b101);
        if (f3 == 3'b100) d.alu = AluXor;
        else if (f3 == 3'b101) d.alu = AluSr;
      end
      OpI: begin
        d.c   = 7'h60;
        d.imm = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'b000:  legal = 1'b1;
          3'b110:  begin legal = 1'b1; d.alu = AluOr;  end
          3'b111:  begin legal = 1'b1; d.alu = AluAnd; end
          3'b101:  begin legal = 1'b1; d.alu = AluSr;  end
          default: legal = 1'b0;
        endcase
      end
      OpLui: begin
        d.c   = 7'h60;
        d.alu = AluSl;
        d.imm = {{12{ins[31]}}, ins[31:12]};
        legal = 1'b1;
      end
      OpLoad: begin
        d.c   = (f3 == 3'b000) ? 7'h76 : 7'h74;
        d.imm = {{20{ins[31]}}, ins[31:20]};
        legal = (f3 == 3'b000) || (f3 == 3'b010);
      end
      OpStore: begin
        d.c   = (f3 == 3'b000) ? 7'h2B : 7'h29;
        d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        legal = (f3 == 3'b000) || (f3 == 3'b010);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d.c   = '0;
      d.alu = AluAdd;
`ifdef DECODE_ILLEGAL_TRAP_EN
      d.imm = '0;
      d.ill = 1'b1;
`endif
    end
    return d;
  endfunction

  // Next-entry contents computed from the incoming bundle
  logic [PC_W*LANES-1:0] pc_d;
  logic [7*LANES-1:0]    c_d;
  logic [3*LANES-1:0]    alu_d;
  logic [32*LANES-1:0]   imm_d;
  logic [5*LANES-1:0]    rd_d, rs1_d, rs2_d;
  logic [LANES-1:0]      ill_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dec_t        dec;
    logic [31:0] ins;
    assign ins                    = in_instr[32*i +: 32];
    assign dec                    = decode(ins);
    assign pc_d[PC_W*i +: PC_W]   = in_pc + PC_W'(4 * i);
    assign c_d[7*i +: 7]          = dec.c;
    assign alu_d[3*i +: 3]        = dec.alu;
    assign imm_d[32*i +: 32]      = dec.imm;
    assign rd_d[5*i +: 5]         = ins[11:7];
    assign rs1_d[5*i +: 5]        = ins[19:15];
    assign rs2_d[5*i +: 5]        = ins[24:20];
    assign ill_d[i]               = dec.ill & in_lane_valid[i];
  end

  logic [LANES-1:0]      lv_q    [2];
  logic [PC_W*LANES-1:0] pc_q    [2];
  logic [32*LANES-1:0]   instr_q [2];
  logic [7*LANES-1:0]    c_q     [2];
  logic [3*LANES-1:0]    alu_q   [2];
  logic [32*LANES-1:0]   imm_q   [2];
  logic [5*LANES-1:0]    rd_q    [2];
  logic [5*LANES-1:0]    rs1_q   [2];
  logic [5*LANES-1:0]    rs2_q   [2];
  logic [LANES-1:0]      ill_q   [2];

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, rd_ptr_q;
  logic       push, pop;

  // in_ready depends only on registered count, so out_ready never reaches it
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        lv_q[e]    <= '0;
        pc_q[e]    <= '0;
        instr_q[e] <= '0;
        c_q[e]     <= '0;
        alu_q[e]   <= '0;
        imm_q[e]   <= '0;
        rd_q[e]    <= '0;
        rs1_q[e]   <= '0;
        rs2_q[e]   <= '0;
        ill_q[e]   <= '0;
      end
    end else if (flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        lv_q[wr_ptr_q]    <= in_lane_valid;
        pc_q[wr_ptr_q]    <= pc_d;
        instr_q[wr_ptr_q] <= in_instr;
        c_q[wr_ptr_q]     <= c_d;
        alu_q[wr_ptr_q]   <= alu_d;
        imm_q[wr_ptr_q]   <= imm_d;
        rd_q[wr_ptr_q]    <= rd_d;
        rs1_q[wr_ptr_q]   <= rs1_d;
        rs2_q[wr_ptr_q]   <= rs2_d;
        ill_q[wr_ptr_q]   <= ill_d;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign out_lane_valid = lv_q[rd_ptr_q];
  assign out_pc         = pc_q[rd_ptr_q];
  assign out_instr      = instr_q[rd_ptr_q];
  assign out_c_sig      = c_q[rd_ptr_q];
  assign out_alu_sig    = alu_q[rd_ptr_q];
  assign out_imm        = imm_q[rd_ptr_q];
  assign out_rd         = rd_q[rd_ptr_q];
  assign out_rs1        = rs1_q[rd_ptr_q];
  assign out_rs2        = rs2_q[rd_ptr_q];
  assign out_illegal    = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with two lanes: decode values, skid buffering, flush, reset.
module tb_decode_stage;

  localparam int unsigned LANES = 2;
  localparam int unsigned PC_W  = 12;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES-1:0]      in_lane_valid;
  logic [PC_W-1:0]       in_pc;
  logic [32*LANES-1:0]   in_instr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_valid;
  logic [PC_W*LANES-1:0] out_pc;
  logic [32*LANES-1:0]   out_instr;
  logic [7*LANES-1:0]    out_c_sig;
  logic [3*LANES-1:0]    out_alu_sig;
  logic [32*LANES-1:0]   out_imm;
  logic [5*LANES-1:0]    out_rd;
  logic [5*LANES-1:0]    out_rs1;
  logic [5*LANES-1:0]    out_rs2;
  logic [LANES-1:0]      out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.LANES(LANES), .PC_W(PC_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_lane_valid (out_lane_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_c_sig      (out_c_sig),
    .out_alu_sig    (out_alu_sig),
    .out_imm        (out_imm),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_illegal    (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] mask, input logic [11:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1);
    in_valid      = v;
    in_lane_valid = mask;
    in_pc         = pc;
    in_instr      = {i1, i0};
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " c_sig"}, 64'(out_c_sig), 64'd0);
    chk({tag, " alu"}, 64'(out_alu_sig), 64'd0);
    chk({tag, " imm"}, out_imm, 64'd0);
    chk({tag, " pc"}, 64'(out_pc), 64'd0);
    chk({tag, " instr"}, out_instr, 64'd0);
    chk({tag, " idx"}, 64'({out_rd, out_rs1, out_rs2}), 64'd0);
    chk({tag, " illegal"}, 64'(out_illegal), 64'd0);
    chk({tag, " lane_valid"}, 64'(out_lane_valid), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 12'h000, 32'h0, 32'h0);
    #3;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b0;

    // addi x1,x0,5 on lane 0, lane 1 masked off with an illegal word
    drive(1'b1, 2'b01, 12'h010, 32'h00500093, 32'h00000000);
    out_ready = 1'b1;
    step();
    chk("addi valid", 64'(out_valid), 64'd1);
    chk("addi c_sig0", 64'(out_c_sig[6:0]), 64'h60);
    chk("addi alu0", 64'(out_alu_sig[2:0]), 64'd0);
    chk("addi imm0", 64'(out_imm[31:0]), 64'h5);
    chk("addi rd0", 64'(out_rd[4:0]), 64'd1);
    chk("addi rs1_0", 64'(out_rs1[4:0]), 64'd0);
    chk("addi lane_valid", 64'(out_lane_valid), 64'b01);
    chk("addi illegal masked", 64'(out_illegal), 64'b00);
    chk("addi pc", 64'(out_pc), 64'h014010);
    in_valid = 1'b0;
    step();
    chk("addi drained", 64'(out_valid), 64'd0);

    // lw x2,-4(x1) plus addi, PC wrap across 0x100
    drive(1'b1, 2'b11, 12'h0FC, 32'hFFC0A103, 32'h00500093);
    step();
    chk("lw c_sig0", 64'(out_c_sig[6:0]), 64'h74);
    chk("lw imm0", 64'(out_imm[31:0]), 64'hFFFFFFFC);
    chk("lw rs1_0", 64'(out_rs1[4:0]), 64'd1);
    chk("lw rd0", 64'(out_rd[4:0]), 64'd2);
    chk("lw rs2_0", 64'(out_rs2[4:0]), 64'h1C);
    chk("lw pc0", 64'(out_pc[11:0]), 64'h0FC);
    chk("lw pc1", 64'(out_pc[23:12]), 64'h100);
    chk("lw c_sig1", 64'(out_c_sig[13:7]), 64'h60);
    chk("lw instr", out_instr, 64'h00500093FFC0A103);
    in_valid = 1'b0;
    step();

    // Backpressure: three bundles offered while rename stalls
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 12'h200, 32'h002082A3, 32'h003140B3);
    step();
    chk("bp1 valid", 64'(out_valid), 64'd1);
    chk("bp1 in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 2'b11, 12'h204, 32'hFE312C23, 32'hFFF27213);
    step();
    chk("bp2 in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b11, 12'h208, 32'h800002B7, 32'h00000000);
    step();
    chk("bp3 in_ready", 64'(in_ready), 64'd0);
    chk("bp3 head pc0", 64'(out_pc[11:0]), 64'h200);
    chk("sb c_sig0", 64'(out_c_sig[6:0]), 64'h2B);
    chk("sb imm0", 64'(out_imm[31:0]), 64'h5);
    chk("sb rs2_0", 64'(out_rs2[4:0]), 64'd2);
    chk("xor c_sig1", 64'(out_c_sig[13:7]), 64'h41);
    chk("xor alu1", 64'(out_alu_sig[5:3]), 64'b001);
    chk("xor imm1", 64'(out_imm[63:32]), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp head2 pc0", 64'(out_pc[11:0]), 64'h204);
    chk("bp head2 in_ready", 64'(in_ready), 64'd1);
    chk("sw c_sig0", 64'(out_c_sig[6:0]), 64'h29);
    chk("sw imm0", 64'(out_imm[31:0]), 64'hFFFFFFF8);
    chk("sw rs2_0", 64'(out_rs2[4:0]), 64'd3);
    chk("andi c_sig1", 64'(out_c_sig[13:7]), 64'h60);
    chk("andi alu1", 64'(out_alu_sig[5:3]), 64'b011);
    chk("andi imm1", 64'(out_imm[63:32]), 64'hFFFFFFFF);
    step();
    chk("bp head3 valid", 64'(out_valid), 64'd1);
    chk("bp head3 pc0", 64'(out_pc[11:0]), 64'h208);
    chk("lui c_sig0", 64'(out_c_sig[6:0]), 64'h60);
    chk("lui alu0", 64'(out_alu_sig[2:0]), 64'b101);
    chk("lui imm0", 64'(out_imm[31:0]), 64'hFFF80000);
    chk("lui rd0", 64'(out_rd[4:0]), 64'd5);
    chk("zero instr c_sig1", 64'(out_c_sig[13:7]), 64'h00);
    chk("zero instr illegal", 64'(out_illegal), 64'({TRAP, 1'b0}));
    in_valid = 1'b0;
    step();
    chk("bp drained", 64'(out_valid), 64'd0);

    // Flush with a full buffer and a bundle on the input
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 12'h300, 32'h00500093, 32'h00500093);
    step();
    drive(1'b1, 2'b11, 12'h304, 32'h00500093, 32'h00500093);
    step();
    chk("fl full in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 2'b11, 12'h308, 32'h00500093, 32'h00500093);
    flush = 1'b1;
    step();
    chk("fl out_valid", 64'(out_valid), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl nothing emitted 1", 64'(out_valid), 64'd0);
    step();
    chk("fl nothing emitted 2", 64'(out_valid), 64'd0);
    // lh is an unsupported load width
    drive(1'b1, 2'b01, 12'h400, 32'h00401083, 32'h00000000);
    step();
    chk("post-fl valid", 64'(out_valid), 64'd1);
    chk("post-fl pc0", 64'(out_pc[11:0]), 64'h400);
    chk("lh c_sig0", 64'(out_c_sig[6:0]), 64'h00);
    chk("lh alu0", 64'(out_alu_sig[2:0]), 64'd0);
    chk("lh imm0", 64'(out_imm[31:0]), TRAP ? 64'd0 : 64'd4);
    chk("lh illegal", 64'(out_illegal), 64'({1'b0, TRAP}));
    chk("lh rd0", 64'(out_rd[4:0]), 64'd1);
    in_valid = 1'b0;
    step();

    // Asynchronous reset while stalled with two entries held
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 12'h500, 32'hFFC0A103, 32'h00500093);
    step();
    drive(1'b1, 2'b11, 12'h504, 32'hFFC0A103, 32'h00500093);
    step();
    chk("pre-rst in_ready", 64'(in_ready), 64'd0);
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midstall rst");
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 12'h600, 32'h00500093, 32'h0);
    step();
    chk("after rst pc0", 64'(out_pc[11:0]), 64'h600);
    chk("after rst c_sig0", 64'(out_c_sig[6:0]), 64'h60);
    in_valid = 1'b0;
    step();
    chk("after rst drained", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked decode stage for the out-of-order core, sitting between fetch and rename. Decodes a bundle of `LANES` instructions per cycle into control signals, ALU op, immediate and register indices. Holds results in a 2-entry output skid buffer so fetch is never stalled by a single-cycle rename backpressure bubble. Supports pipeline flush and illegal-opcode flagging.

## Interface
- `LANES`, 1: instructions per bundle (1 or 2).
- `PC_W`, 12: PC width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch bundle valid.
- `in_ready`  out  1  stage can accept a bundle this cycle.
- `in_lane_valid`  in  LANES  per-lane valid mask; lane 0 is oldest.
- `in_pc`  in  PC_W  PC of lane 0; lane i PC = `in_pc + 4*i`, truncated to PC_W.
- `in_instr`  in  32*LANES  lane i at bits [32*i+31:32*i].
- `flush`  in  1  discard all buffered and incoming bundles.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  rename accepts the bundle.
- `out_lane_valid`  out  LANES  mask carried from input.
- `out_pc`  out  PC_W*LANES  per-lane PC.
- `out_instr`  out  32*LANES  raw instruction, passed through.
- `out_c_sig`  out  7*LANES  control bits, per lane: [6] reg_write, [5] alu_src_imm, [4] mem_read, [3] mem_write, [2] mem_to_reg, [1] byte_access, [0] uses_rs2.
- `out_alu_sig`  out  3*LANES  ALU op: ADD 000, XOR 001, OR 010, AND 011, SHIFT_RIGHT 100, SHIFT_LEFT 101.
- `out_imm`  out  32*LANES  sign-extended immediate.
- `out_rd`, `out_rs1`, `out_rs2`  out  5*LANES each  instr[11:7], [19:15], [24:20].
- `out_illegal`  out  LANES  unsupported encoding.

## Operation
- Combinational decode per lane, registered on acceptance (`in_valid && in_ready`).
- Control values: R-type (0110011) 0x41; I-type (0010011) 0x60; LUI (0110111) 0x60; LB 0x76; LW 0x74; SB 0x2B; SW 0x29; anything else 0x00.
- ALU: load/store ADD; LUI SHIFT_LEFT; R-type funct3 000 ADD, 100 XOR, 101 SHIFT_RIGHT; I-type 000 ADD, 110 OR, 111 AND, 101 SHIFT_RIGHT; all else 000.
- Immediate: I-type/load sext(instr[31:20]); store sext({instr[31:25],instr[11:7]}); LUI sext(instr[31:12]); R-type and others 0.
- Legal set: opcodes above with listed funct3 values; load/store funct3 000 or 010 only. Every other encoding is illegal.
- Invalid lanes (mask bit 0) still decode but are don't-care downstream; `out_illegal` is forced 0 for them.
- Buffer: 2-entry FIFO, head drives outputs. `in_ready = !(count == 2)`; `out_valid = (count != 0)`.
- Simultaneous accept and emit with count 2 is not allowed (in_ready low); with count 1 count stays 1, order preserved.

## Timing
- Latency 1 cycle: bundle accepted at edge N appears on outputs after edge N with `count` updated.
- Outputs of head entry stable while `out_valid && !out_ready`.
- `flush` sampled at edge: count := 0, same-cycle input bundle dropped even if `in_valid && in_ready`. Next cycle `out_valid = 0`, `in_ready = 1`.
- Reset (any time, including mid-stall): count 0, `out_valid` 0, `in_ready` 1, all data outputs 0 (`out_c_sig`, `out_alu_sig`, `out_imm`, `out_pc`, `out_instr`, indices, `out_illegal`, `out_lane_valid`).
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: illegal lane drives `out_illegal` 1, control 0x00, ALU 000, imm 0.
- Not defined: `out_illegal` tied 0; illegal encodings fall back to the default decode above (control 0x00, ALU 000, imm per opcode rule).

## Test plan
- Reset: assert `rst` mid-stall with count 2 -> immediately `out_valid` 0, `in_ready` 1, all outputs 0.
- Lane 0 0x00500093 (addi x1,x0,5) -> next cycle c_sig 0x60, alu 000, imm 0x00000005, rd 1, rs1 0.
- LANES=2, `in_pc` 0x0FC, lanes 0xFFC0A103 / 0x00500093 -> lane 0 c_sig 0x74, imm 0xFFFFFFFC, rs1 1, rd 2, pc 0x0FC; lane 1 pc 0x100.
- `out_ready` low 3 cycles, 3 bundles offered -> first two accepted, `in_ready` 0 on 3rd, released in order once `out_ready` rises, none lost.
- Count 2 plus `flush` with `in_valid` 1 -> next cycle `out_valid` 0, `in_ready` 1, dropped bundle never emitted.
- Instr 0x00000000 -> with macro `out_illegal` 1, c_sig 0x00; without macro `out_illegal` 0, c_sig 0x00.
